length_str: RTL and testbench

Null-terminated string length counter for the BWT front end. It scans a packed 1024-byte string buffer one byte per clock, starting at byte 0, and reports how many non-zero bytes come before the first zero byte. The result `N` is the string length the BWT/IBWT blocks use as their working length.

---
 rtl/length_str_if.sv | 16 +
 rtl/length_str.sv | 82 ++++++++
 tb/tb_length_str.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/length_str_if.sv
// Bus bundle for the string-length counter: the packed string going in,
// and the running count and status flags coming back.
interface length_str_if #(
  parameter int MAX_BYTES = 1024,
  parameter int LEN_W     = 10
);
  logic [MAX_BYTES*8-1:0] str;
  logic [LEN_W-1:0]       N;
  logic                   done;
  logic                   full;

  // The testbench or upstream block supplies the string and observes the result
  modport master (output str, input N, input done, input full);
  // The counter reads the string and produces the result
  modport slave  (input str, output N, output done, output full);
endinterface

// File: rtl/length_str.sv
// Null-terminated string length counter. Walks the packed string one byte
// per clock from byte 0 and counts non-zero bytes up to the first 0x00, or
// up to the end of the buffer (flagged as full).
module length_str #(
  parameter int MAX_BYTES = 1024,
  parameter int LEN_W     = 10
) (
  input logic         clk,
  input logic         rst,
  length_str_if.slave bus
);
  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BYTES - 1);

  typedef enum logic {SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic             done_q, done_d;
  logic             full_q, full_d;
  logic [7:0]       cur_byte;

  // Count increment that sticks at all-ones instead of wrapping
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    if (v == {LEN_W{1'b1}}) return v;
    return v + LEN_W'(1);
  endfunction

  assign cur_byte = bus.str[idx_q*8 +: 8];

  // State and result registers; reset takes effect without a clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SCAN;
      idx_q   <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  // Scan step: stop on the terminator or on the last byte, otherwise advance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    done_d  = done_q;
    full_d  = full_q;
    unique case (state_q)
      SCAN: begin
        if (cur_byte == 8'h00) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          // Last byte is non-zero: no terminator within the buffer
          state_d = DONE;
          done_d  = 1'b1;
          full_d  = 1'b1;
          n_d     = sat_inc(n_q);
        end else begin
          n_d   = sat_inc(n_q);
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        // Everything holds until the next reset
      end
      default: state_d = SCAN;
    endcase
  end

  assign bus.N    = n_q;
  assign bus.done = done_q;
  assign bus.full = full_q;
endmodule

// File: tb/tb_length_str.sv
// Self-checking bench for length_str: expected length, completion edge and
// full flag are queued when a string is loaded and checked when done rises.
module tb_length_str;
  localparam int MAX_BYTES = 1024;
  localparam int LEN_W     = 10;

  typedef struct {
    int n;
    int edges;
    int full;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  length_str_if #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) bus ();

  length_str #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_str();
    bus.str = '0;
  endtask

  task automatic fill_str(input int len, input logic [7:0] val);
    for (int k = 0; k < len; k++) bus.str[8*k +: 8] = val;
  endtask

  // Assert reset between edges, check outputs clear at once, release on a falling edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_N", 32'(bus.N), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_full", 32'(bus.full), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Count edges until done, optionally checking the partial count each edge
  task automatic run_scan(input string tag, input bit per_edge);
    int   edges = 0;
    bit   tmo = 1'b0;
    exp_t e;
    while (1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) break;
      if (per_edge) chk({tag, "_partial"}, 32'(bus.N), 32'(edges));
      if (edges >= 1100) begin
        tmo = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(tmo), 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_N"}, 32'(bus.N), 32'(e.n));
      chk({tag, "_edge"}, 32'(edges), 32'(e.edges));
      chk({tag, "_full"}, 32'(bus.full), 32'(e.full));
    end
  endtask

  initial begin
    logic [47:0] banana;
    logic [31:0] xyzw;
    rst = 1'b0;
    bus.str = '0;
    #12;

    // "banana": bytes 0..5, rest zero
    clear_str();
    banana = {8'h61, 8'h6E, 8'h61, 8'h6E, 8'h61, 8'h62};
    bus.str[47:0] = banana;
    do_reset();
    sb.push_back('{n: 6, edges: 7, full: 0});
    run_scan("banana", 1'b1);

    // Empty string, and the count holds afterwards
    clear_str();
    do_reset();
    sb.push_back('{n: 0, edges: 1, full: 0});
    run_scan("empty", 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("empty_hold_N", 32'(bus.N), 0);
    chk("empty_hold_done", 32'(bus.done), 1);

    // 1023 x 0xFF then terminator in the last byte
    clear_str();
    fill_str(1023, 8'hFF);
    do_reset();
    sb.push_back('{n: 1023, edges: 1024, full: 0});
    run_scan("ff1023", 1'b1);

    // Every byte non-zero: no terminator, count saturates
    clear_str();
    fill_str(1024, 8'h41);
    do_reset();
    sb.push_back('{n: 1023, edges: 1024, full: 1});
    run_scan("full", 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("full_hold_N", 32'(bus.N), 1023);

    // "ab",0,"cd" then change the string after done
    clear_str();
    bus.str[7:0]   = 8'h61;
    bus.str[15:8]  = 8'h62;
    bus.str[31:24] = 8'h63;
    bus.str[39:32] = 8'h64;
    do_reset();
    sb.push_back('{n: 2, edges: 3, full: 0});
    run_scan("ab", 1'b1);
    xyzw = {8'h77, 8'h7A, 8'h79, 8'h78};
    bus.str[31:0] = xyzw;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ab_hold_N", 32'(bus.N), 2);
    chk("ab_hold_done", 32'(bus.done), 1);
    chk("ab_hold_full", 32'(bus.full), 0);

    // 100-byte string aborted mid-scan by reset, then rescanned
    clear_str();
    for (int k = 0; k < 100; k++) bus.str[8*k +: 8] = 8'(k + 1);
    do_reset();
    repeat (40) @(posedge clk);
    #2;
    chk("mid_N40", 32'(bus.N), 40);
    rst = 1'b0;
    #1;
    chk("mid_rst_N", 32'(bus.N), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_full", 32'(bus.full), 0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{n: 100, edges: 101, full: 0});
    run_scan("s100", 1'b1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
